// File: rtl/tag_fifo_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tag_fifo_scheduler_pkg
//  Purpose  : Shared widths, entry/tag layouts and tag helper for the
//             DRAM-cache tag scheduling path.
//  Revision : 1.0 - initial release
// ============================================================================
package tag_fifo_scheduler_pkg;

  localparam int DEF_ADDR_WIDTH = 64;
  localparam int DEF_TID_WIDTH  = 16;
  localparam int DEF_TAG_WIDTH  = 56;
  localparam int DEF_MAX_PEND   = 8;
  // Stored tag bits: the tag word minus its valid and dirty flags
  localparam int DEF_TAG_BITS   = DEF_TAG_WIDTH - 2;

  // One tag FIFO entry; packed MSB-first as {write, addr, tid}
  typedef struct packed {
    logic                      write;
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_TID_WIDTH-1:0]  tid;
  } tag_fifo_entry_t;

  // Returned DRAM-cache tag word
  typedef struct packed {
    logic                    valid;
    logic                    dirty;
    logic [DEF_TAG_BITS-1:0] tag;
  } rtag_t;

  // Tag portion of an address: the top TAG_BITS address bits
  function automatic logic [DEF_TAG_BITS-1:0] tag_of(input logic [DEF_ADDR_WIDTH-1:0] addr);
    return addr[DEF_ADDR_WIDTH-1 -: DEF_TAG_BITS];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tag_fifo_scheduler_pend_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tag_fifo_scheduler_pend_queue
//  Purpose  : In-order circular queue of arbitrary entry type. Holds entries
//             that were issued but whose response has not yet returned.
//  Revision : 1.0 - initial release
// ============================================================================
module tag_fifo_scheduler_pend_queue #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output T                         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop only when occupied; push when there is room or a slot frees this cycle
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/tag_fifo_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tag_fifo_scheduler
//  Purpose  : Pops tag FIFO entries under a credit limit, parks them in an
//             in-order pending queue, pairs each returned cache tag with the
//             oldest entry and presents a registered hit/miss/dirty result.
//  Revision : 1.0 - initial release
// ============================================================================
module tag_fifo_scheduler
  import tag_fifo_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TID_WIDTH  = DEF_TID_WIDTH,
  parameter int TAG_WIDTH  = DEF_TAG_WIDTH,
  parameter int MAX_PEND   = DEF_MAX_PEND
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          aempty_i,
  output logic                          rden_o,
  input  logic [ADDR_WIDTH+TID_WIDTH:0] fifo_data_i,
  input  logic                          rtag_valid_i,
  input  logic [TAG_WIDTH-1:0]          rtag_i,
  output logic                          rtag_ready_o,
  output logic                          res_valid_o,
  input  logic                          res_ready_i,
  output logic                          res_hit_o,
  output logic                          res_dirty_o,
  output logic                          res_write_o,
  output logic [ADDR_WIDTH-1:0]         res_addr_o,
  output logic [TID_WIDTH-1:0]          res_tid_o,
  output logic [$clog2(MAX_PEND):0]     pend_cnt_o
);

  localparam int CNT_W    = $clog2(MAX_PEND) + 1;
  localparam int TAG_BITS = TAG_WIDTH - 2;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [TID_WIDTH-1:0]  tid;
  } entry_t;

  logic             pop_in_flight;
  logic [CNT_W-1:0] pend_cnt;
  logic [CNT_W:0]   credit_used;
  entry_t           fifo_entry;
  entry_t           head;
  logic             tag_hs;
  logic             tag_hit;

  assign fifo_entry = entry_t'(fifo_data_i);

  // Credit covers both queued entries and the one whose data is still arriving
  assign credit_used  = {1'b0, pend_cnt} + {{CNT_W{1'b0}}, pop_in_flight};
  assign rden_o       = !rst && !aempty_i && (credit_used < (CNT_W+1)'(MAX_PEND));

  // A tag is only taken when there is an entry to pair it with and room for the result
  assign rtag_ready_o = (pend_cnt != '0) && (!res_valid_o || res_ready_i);
  assign tag_hs       = rtag_valid_i && rtag_ready_o;

  // A tag-equal line whose valid bit is clear is still a miss
  assign tag_hit    = rtag_i[TAG_WIDTH-1] &&
                      (rtag_i[TAG_BITS-1:0] == head.addr[ADDR_WIDTH-1 -: TAG_BITS]);
  assign pend_cnt_o = pend_cnt;

  tag_fifo_scheduler_pend_queue #(
    .DEPTH (MAX_PEND),
    .T     (entry_t)
  ) u_pend_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (pop_in_flight),
    .push_data (fifo_entry),
    .pop       (tag_hs),
    .count     (pend_cnt),
    .head      (head)
  );

  // FIFO read data arrives one cycle after the pop strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pop_in_flight <= 1'b0;
    end else begin
      pop_in_flight <= rden_o;
    end
  end

  // Single result slot: load on tag handshake, drain on consumer handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_o <= 1'b0;
      res_hit_o   <= 1'b0;
      res_dirty_o <= 1'b0;
      res_write_o <= 1'b0;
      res_addr_o  <= '0;
      res_tid_o   <= '0;
    end else if (tag_hs) begin
      res_valid_o <= 1'b1;
      res_hit_o   <= tag_hit;
      res_dirty_o <= rtag_i[TAG_WIDTH-2];
      res_write_o <= head.write;
      res_addr_o  <= head.addr;
      res_tid_o   <= head.tid;
    end else if (res_valid_o && res_ready_i) begin
      res_valid_o <= 1'b0;
    end
  end

`ifndef SYNTHESIS
  // A returned tag with nothing outstanding is a protocol error upstream
  sva_tag_without_req: assert property (@(posedge clk) disable iff (rst)
    !(rtag_valid_i && (pend_cnt == '0)))
    else $error("tag_fifo_scheduler: rtag_valid_i with empty pending queue");
`endif

endmodule
`default_nettype wire

// File: tb/tb_tag_fifo_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tag_fifo_scheduler
//  Purpose  : Directed and randomised scoreboard bench for tag_fifo_scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tag_fifo_scheduler;
  import tag_fifo_scheduler_pkg::*;

  localparam int AW = 64;
  localparam int TW = 16;
  localparam int GW = 56;
  localparam int MP = 8;
  localparam int CW = $clog2(MP) + 1;

  logic              clk;
  logic              rst;
  logic              aempty_i;
  logic              rden_o;
  logic [AW+TW:0]    fifo_data_i;
  logic              rtag_valid_i;
  logic [GW-1:0]     rtag_i;
  logic              rtag_ready_o;
  logic              res_valid_o;
  logic              res_ready_i;
  logic              res_hit_o;
  logic              res_dirty_o;
  logic              res_write_o;
  logic [AW-1:0]     res_addr_o;
  logic [TW-1:0]     res_tid_o;
  logic [CW-1:0]     pend_cnt_o;

  tag_fifo_scheduler #(
    .ADDR_WIDTH (AW),
    .TID_WIDTH  (TW),
    .TAG_WIDTH  (GW),
    .MAX_PEND   (MP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .aempty_i     (aempty_i),
    .rden_o       (rden_o),
    .fifo_data_i  (fifo_data_i),
    .rtag_valid_i (rtag_valid_i),
    .rtag_i       (rtag_i),
    .rtag_ready_o (rtag_ready_o),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_hit_o    (res_hit_o),
    .res_dirty_o  (res_dirty_o),
    .res_write_o  (res_write_o),
    .res_addr_o   (res_addr_o),
    .res_tid_o    (res_tid_o),
    .pend_cnt_o   (pend_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          hit;
    logic          dirty;
    logic          write;
    logic [AW-1:0] addr;
    logic [TW-1:0] tid;
  } res_t;

  // Environment model: external tag FIFO, in-flight pop, pending entries, expected results
  tag_fifo_entry_t fifo_q[$];
  tag_fifo_entry_t pend_q[$];
  res_t            exp_q[$];
  logic [TW-1:0]   got_tids[$];
  tag_fifo_entry_t fly_entry;
  bit              fly_valid;
  bit              tag_live;
  res_t            cur_exp;

  // Stimulus controls
  bit tag_en, tag_rand, rdy_rand, rdy_fixed, force_aempty;
  bit dir_v, dir_d, dir_m;
  int tag_budget;

  int n_assert, n_fail, n_res;

  // Values sampled at the falling edge
  logic          s_rden, s_taghs, s_reshs, s_rtag_ready, s_res_valid;
  logic          s_hit, s_dirty, s_write;
  logic [AW-1:0] s_addr;
  logic [TW-1:0] s_tid;
  logic [CW-1:0] s_pend;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
      end
  endtask

  function automatic tag_fifo_entry_t mk(input bit w, input logic [AW-1:0] a, input logic [TW-1:0] t);
    tag_fifo_entry_t e;
    e.write = w;
    e.addr  = a;
    e.tid   = t;
    return e;
  endfunction

  // Drive aempty and the returned tag from the model state
  task automatic sync_inputs();
    bit v, d, m;
    logic [GW-3:0] t;
    aempty_i = force_aempty || (fifo_q.size() == 0);
    if (tag_en && tag_budget != 0 && pend_q.size() != 0) begin
      if (!tag_live) begin
        if (tag_rand) begin
          v = ($urandom_range(0, 3) != 0);
          d = 1'($urandom_range(0, 1));
          m = 1'($urandom_range(0, 1));
        end else begin
          v = dir_v; d = dir_d; m = dir_m;
        end
        t = tag_of(pend_q[0].addr);
        if (!m) t[0] = ~t[0];
        rtag_i        = {v, d, t};
        cur_exp.hit   = v && m;
        cur_exp.dirty = d;
        cur_exp.write = pend_q[0].write;
        cur_exp.addr  = pend_q[0].addr;
        cur_exp.tid   = pend_q[0].tid;
        tag_live      = 1'b1;
      end
      rtag_valid_i = 1'b1;
    end else begin
      rtag_valid_i = 1'b0;
      tag_live     = 1'b0;
    end
  endtask

  // One clock: sample/score at negedge, then advance the model after posedge
  task automatic cycle();
    res_t e;
    @(negedge clk);
    s_rden       = rden_o;
    s_rtag_ready = rtag_ready_o;
    s_taghs      = rtag_valid_i && rtag_ready_o;
    s_res_valid  = res_valid_o;
    s_reshs      = res_valid_o && res_ready_i;
    s_hit        = res_hit_o;
    s_dirty      = res_dirty_o;
    s_write      = res_write_o;
    s_addr       = res_addr_o;
    s_tid        = res_tid_o;
    s_pend       = pend_cnt_o;
    chk("pend_cnt", s_pend, pend_q.size());
    if (s_reshs) begin
      n_res++;
      got_tids.push_back(s_tid);
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("res_hit",   s_hit,   e.hit);
        chk("res_dirty", s_dirty, e.dirty);
        chk("res_write", s_write, e.write);
        chk("res_addr",  s_addr,  e.addr);
        chk("res_tid",   s_tid,   e.tid);
      end
    end
    @(posedge clk);
    #1;
    if (s_taghs) begin
      exp_q.push_back(cur_exp);
      if (pend_q.size() != 0) void'(pend_q.pop_front());
      tag_live = 1'b0;
      if (tag_budget > 0) tag_budget--;
    end
    if (fly_valid) pend_q.push_back(fly_entry);
    fly_valid = 1'b0;
    if (s_rden && fifo_q.size() != 0) begin
      fly_entry   = fifo_q.pop_front();
      fifo_data_i = fly_entry;
      fly_valid   = 1'b1;
    end
    res_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fixed;
    sync_inputs();
  endtask

  task automatic wait_res(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycle();
      ok = s_res_valid;
    end
    chk("wait_res_timeout", ok, 1);
  endtask

  task automatic drain(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      cycle();
      ok = (fifo_q.size() == 0) && !fly_valid && (pend_q.size() == 0) && (exp_q.size() == 0);
    end
    chk("drain_timeout", ok, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    pend_q.delete();
    exp_q.delete();
    fly_valid   = 1'b0;
    tag_live    = 1'b0;
    fifo_data_i = '0;
    sync_inputs();
  endtask

  initial begin
    int pops;
    logic [TW-1:0] snap_tid;
    logic [AW-1:0] snap_addr;

    n_assert = 0; n_fail = 0; n_res = 0;
    rst = 1'b1; fifo_data_i = '0; rtag_valid_i = 1'b0; rtag_i = '0; res_ready_i = 1'b1;
    tag_en = 0; tag_rand = 0; rdy_rand = 0; rdy_fixed = 1; force_aempty = 0;
    dir_v = 1; dir_d = 0; dir_m = 1; tag_budget = -1;
    fly_valid = 0; tag_live = 0;
    sync_inputs();

    // Power-on reset state
    cycle();
    chk("rst_rden",        s_rden,       0);
    chk("rst_rtag_ready",  s_rtag_ready, 0);
    chk("rst_res_valid",   s_res_valid,  0);
    chk("rst_res_payload", {s_hit, s_dirty, s_write, s_addr, s_tid}, 0);
    rst = 1'b0;
    cycle();

    // Test 1: reset with pend_cnt=3 and a held result
    for (int i = 0; i < 4; i++) fifo_q.push_back(mk(0, 64'h0000_0A00_0000_0000 + 64'(i), 16'h0011 + 16'(i)));
    tag_en = 1; rdy_fixed = 0; res_ready_i = 0;
    sync_inputs();
    repeat (10) cycle();
    chk("t1_pend_before_rst",  s_pend,      3);
    chk("t1_valid_before_rst", s_res_valid, 1);
    force_aempty = 1;
    fifo_q.push_back(mk(0, 64'h0000_0B00_0000_0000, 16'h0015));
    apply_reset();
    force_aempty = 0;
    sync_inputs();
    cycle();
    chk("t1_rst_rden",       s_rden,       0);
    chk("t1_rst_rtag_ready", s_rtag_ready, 0);
    chk("t1_rst_res_valid",  s_res_valid,  0);
    chk("t1_rst_payload",    {s_hit, s_dirty, s_write, s_addr, s_tid}, 0);
    chk("t1_rst_pend",       s_pend,       0);
    rst = 1'b0; tag_en = 0;
    sync_inputs();
    repeat (4) begin
      cycle();
      chk("t1_no_stale_result", s_res_valid, 0);
    end
    tag_en = 1; rdy_fixed = 1;
    sync_inputs();
    drain(50);

    // Test 2: single read hit with exact latency
    dir_v = 1; dir_d = 0; dir_m = 1;
    fifo_q.push_back(mk(0, 64'h0000_1234_5678_9C00, 16'h0007));
    sync_inputs();
    cycle();
    chk("t2_rden_T", s_rden, 1);
    cycle();
    chk("t2_rden_T1", s_rden, 0);
    chk("t2_pend_T1", s_pend, 0);
    cycle();
    chk("t2_pend_T2",       s_pend,       1);
    chk("t2_rtag_ready_T2", s_rtag_ready, 1);
    chk("t2_tag_hs_T2",     s_taghs,      1);
    chk("t2_res_valid_T2",  s_res_valid,  0);
    cycle();
    chk("t2_res_valid_T3", s_res_valid, 1);
    chk("t2_hit",   s_hit,   1);
    chk("t2_tid",   s_tid,   16'h0007);
    chk("t2_write", s_write, 0);
    chk("t2_addr",  s_addr,  64'h0000_1234_5678_9C00);
    cycle();
    chk("t2_res_cleared", s_res_valid, 0);

    // Test 3: dirty write miss
    dir_v = 1; dir_d = 1; dir_m = 0;
    fifo_q.push_back(mk(1, 64'hFFFF_0000_0000_0400, 16'hABCD));
    sync_inputs();
    wait_res(10);
    chk("t3_hit",   s_hit,   0);
    chk("t3_dirty", s_dirty, 1);
    chk("t3_write", s_write, 1);
    chk("t3_addr",  s_addr,  64'hFFFF_0000_0000_0400);
    chk("t3_tid",   s_tid,   16'hABCD);
    drain(20);

    // Test 4: credit limit, then one tag frees exactly one pop
    tag_en = 0;
    for (int i = 0; i < 12; i++) fifo_q.push_back(mk(i[0], {32'hC0DE_0000, 32'(i)}, 16'h0200 + 16'(i)));
    sync_inputs();
    pops = 0;
    repeat (20) begin
      cycle();
      pops += int'(s_rden);
    end
    chk("t4_pops",      pops,   MP);
    chk("t4_pend_sat",  s_pend, MP);
    chk("t4_rden_idle", s_rden, 0);
    tag_en = 1; tag_budget = 1; dir_v = 0; dir_d = 0; dir_m = 1;
    sync_inputs();
    pops = 0;
    repeat (10) begin
      cycle();
      pops += int'(s_rden);
    end
    chk("t4_extra_pops", pops,   1);
    chk("t4_pend_again", s_pend, MP);
    tag_budget = -1;
    sync_inputs();
    drain(100);

    // Test 5: result backpressure, payload held, order preserved
    dir_v = 1; dir_d = 0; dir_m = 1;
    for (int i = 1; i <= 3; i++) fifo_q.push_back(mk(0, 64'h0000_0000_0005_0000 + 64'(i << 10), 16'(i)));
    rdy_fixed = 0; res_ready_i = 0;
    got_tids.delete();
    sync_inputs();
    wait_res(20);
    snap_tid  = s_tid;
    snap_addr = s_addr;
    repeat (5) begin
      cycle();
      chk("t5_rtag_ready_low", s_rtag_ready, 0);
      chk("t5_res_valid_held", s_res_valid,  1);
      chk("t5_tid_stable",     s_tid,        snap_tid);
      chk("t5_addr_stable",    s_addr,       snap_addr);
    end
    rdy_fixed = 1; res_ready_i = 1;
    drain(50);
    chk("t5_count", got_tids.size(), 3);
    chk("t5_order", {got_tids.size() > 0 ? got_tids[0] : 16'hFFFF,
                     got_tids.size() > 1 ? got_tids[1] : 16'hFFFF,
                     got_tids.size() > 2 ? got_tids[2] : 16'hFFFF},
                    {16'd1, 16'd2, 16'd3});

    // Test 6: 40-entry random stream through pointer wrap with toggling ready
    tag_rand = 1; rdy_rand = 1; n_res = 0;
    for (int i = 0; i < 40; i++) fifo_q.push_back(mk(1'($urandom_range(0, 1)), {$urandom, $urandom}, 16'h1000 + 16'(i)));
    sync_inputs();
    drain(2000);
    chk("t6_result_count", n_res, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
